data_memory_controller: RTL and testbench
=========================================

Name: data_memory_controller

Overview:
- Responder end of the LSU data-memory interface.
- Accepts read/write requests from NUM_CONSUMERS LSUs and multiplexes them onto NUM_CHANNELS external data-memory channels.
- Relays read data and write completion back as single-cycle ready pulses.
- Sits between the per-thread LSUs of a core and the data memory model/bus.

Parameters:
- NUM_CONSUMERS, 8, number of LSU request ports.
- NUM_CHANNELS, 2, number of concurrent memory channels (1..NUM_CONSUMERS).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- consumer_read_valid  in  [NUM_CONSUMERS]  per-LSU read request, held until acknowledged.
- consumer_read_address  in  [NUM_CONSUMERS] x data_memory_address_t  read address.
- consumer_read_ready  out  [NUM_CONSUMERS]  one-cycle pulse; read data valid.
- consumer_read_data  out  [NUM_CONSUMERS] x data_t  returned read data.
- consumer_write_valid  in  [NUM_CONSUMERS]  per-LSU write request.
- consumer_write_address  in  [NUM_CONSUMERS] x data_memory_address_t  write address.
- consumer_write_data  in  [NUM_CONSUMERS] x data_t  write data.
- consumer_write_ready  out  [NUM_CONSUMERS]  one-cycle pulse; write complete.
- mem_read_valid  out  [NUM_CHANNELS]  read request to memory, held until mem_read_ready.
- mem_read_address  out  [NUM_CHANNELS] x data_memory_address_t
- mem_read_ready  in  [NUM_CHANNELS]  memory read response.
- mem_read_data  in  [NUM_CHANNELS] x data_t
- mem_write_valid  out  [NUM_CHANNELS]
- mem_write_address  out  [NUM_CHANNELS] x data_memory_address_t
- mem_write_data  out  [NUM_CHANNELS] x data_t
- mem_write_ready  in  [NUM_CHANNELS]  memory write acknowledge.

Behaviour:
- All outputs are registered. Reset value of every output is 0. Reset also clears channel states to CH_IDLE, channel_consumer, the claimed mask and the round-robin pointers.
- Reset mid-transaction drops the transaction silently; no ready pulse is ever issued for it.
- Per-channel FSM:
  - CH_IDLE: select a consumer that has read_valid or write_valid set, is not claimed by any channel, and is not in release.
    - Selection is the first such index at or after rr_ptr[ch], with wrap-around.
    - On a hit, record channel_consumer and set claimed[c]. For a read, drive mem_read_valid=1 and mem_read_address and go to CH_READ_WAITING. For a write, drive mem_write_valid, mem_write_address and mem_write_data and go to CH_WRITE_WAITING.
    - If both read_valid and write_valid are set, the read wins.
  - CH_READ_WAITING: hold the request until mem_read_ready=1. Then drop mem_read_valid, set consumer_read_data[c]=mem_read_data, pulse consumer_read_ready[c]=1, go to CH_RELAYING.
  - CH_WRITE_WAITING: likewise on mem_write_ready. Drop mem_write_valid, pulse consumer_write_ready[c]=1, go to CH_RELAYING.
  - CH_RELAYING: clear the ready pulse (exactly 1 cycle high). Wait until both consumer valids of c are 0, then clear claimed[c], set rr_ptr[ch]=(c+1) mod NUM_CONSUMERS, go to CH_IDLE.
- Release rule: the LSU drops valid one cycle after seeing ready. The controller must therefore never re-serve a still-high stale valid.
- Latency: consumer valid high at edge k, earliest mem valid at edge k+1. Memory ready at edge m produces consumer ready visible after edge m+1.
- Same-cycle claim conflict: channels evaluated in ascending index; a consumer taken by a lower channel is unavailable to higher channels in that same cycle.
- Read data register for consumer c holds its value until overwritten by that consumer's next read.
- Consumer valid dropped before service (protocol violation): the request is ignored if not yet claimed. Once claimed, the transaction completes normally and ready is still pulsed.
- NUM_CHANNELS=1 degenerates to a serial round-robin server.

Decomposition:
- Shared package gains mem_channel_state_t (CH_IDLE, CH_READ_WAITING, CH_WRITE_WAITING, CH_RELAYING).
- Reuse the existing data_t and data_memory_address_t.
- Keep the block as one module: the cross-channel claim chain is the core logic and does not split cleanly.
- Optional helper function for round-robin first-set search with wrap.

Test Plan:
- Single read: consumer 3 reads addr 0x10, memory returns 0x00AB after 2 cycles -> mem_read_address[0]=0x10; consumer_read_ready[3] high exactly 1 cycle; consumer_read_data[3]=0x00AB; no second mem request while valid decays.
- Single write: consumer 0 writes 0x0055 to addr 0x20 -> mem_write_address=0x20, mem_write_data=0x0055; consumer_write_ready[0] pulses once; channel returns to CH_IDLE.
- Contention: all 8 consumers read addr=index simultaneously, 2 channels, memory ready after 1 cycle -> consumers 0 and 1 are issued first; all 8 served exactly once; no consumer is on two channels at once.
- Round-robin fairness: consumers 0 and 5 re-request continuously with NUM_CHANNELS=1 -> service alternates 0, 5, 0, 5.
- Reset mid-operation: assert reset while channel 0 is in CH_READ_WAITING -> all outputs are 0 immediately; no consumer_read_ready pulse follows; a fresh request after reset is served normally.
- Simultaneous read+write from consumer 2 -> the read is served first; the write is served after release and re-request.

Source files
------------

// File: rtl/data_memory_controller_pkg.sv
// Shared types for the LSU <-> data-memory path.
//   data_t                : one data-memory word
//   data_memory_address_t : data-memory word address
//   mem_channel_state_t   : per-channel state of data_memory_controller
package data_memory_controller_pkg;

    localparam int DATA_WIDTH                = 16;
    localparam int DATA_MEMORY_ADDRESS_WIDTH = 8;

    typedef logic [DATA_WIDTH-1:0]                data_t;
    typedef logic [DATA_MEMORY_ADDRESS_WIDTH-1:0] data_memory_address_t;

    typedef enum logic [1:0] {
        CH_IDLE          = 2'd0,
        CH_READ_WAITING  = 2'd1,
        CH_WRITE_WAITING = 2'd2,
        CH_RELAYING      = 2'd3
    } mem_channel_state_t;

endpackage

// File: rtl/data_memory_controller.sv
// data_memory_controller: responder end of the LSU data-memory interface.
// Multiplexes read/write requests from NUM_CONSUMERS LSUs onto NUM_CHANNELS
// memory channels and returns completion as one-cycle ready pulses.
//
// Ports:
//   clk, reset                     clock; asynchronous active-high reset
//   consumer_read_*  / consumer_write_*   LSU side (valid/address/data in,
//                                          ready pulse and read data out)
//   mem_read_*       / mem_write_*        memory side, one set per channel
//   channel_state                  per-channel FSM state (debug visibility)
//
// Handshake: a consumer holds valid (and its address/data) until it sees its
// one-cycle ready pulse, then drops valid one cycle later. On the memory side
// the controller holds mem_*_valid with stable address/data until it samples
// mem_*_ready high, and drops valid on that same edge.
module data_memory_controller
    import data_memory_controller_pkg::*;
#(
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CONSUMERS-1:0]  consumer_read_valid,
    input  data_memory_address_t      consumer_read_address  [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0]  consumer_read_ready,
    output data_t                     consumer_read_data     [NUM_CONSUMERS],
    input  logic [NUM_CONSUMERS-1:0]  consumer_write_valid,
    input  data_memory_address_t      consumer_write_address [NUM_CONSUMERS],
    input  data_t                     consumer_write_data    [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0]  consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]   mem_read_valid,
    output data_memory_address_t      mem_read_address       [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0]   mem_read_ready,
    input  data_t                     mem_read_data          [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0]   mem_write_valid,
    output data_memory_address_t      mem_write_address      [NUM_CHANNELS],
    output data_t                     mem_write_data         [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0]   mem_write_ready,
    output mem_channel_state_t        channel_state          [NUM_CHANNELS]
);

    localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    typedef logic [CW-1:0] idx_t;

    idx_t                     channel_consumer [NUM_CHANNELS];
    idx_t                     rr_ptr           [NUM_CHANNELS];
    // A consumer stays claimed through CH_RELAYING, so a stale valid that is
    // still high after the ready pulse can never be picked up again.
    logic [NUM_CONSUMERS-1:0] claimed;

    logic pick_hit [NUM_CHANNELS];
    idx_t pick_idx [NUM_CHANNELS];

    // First set bit of req at or after ptr, wrapping; MSB of result = found.
    function automatic logic [CW:0] rr_pick(input logic [NUM_CONSUMERS-1:0] req,
                                            input idx_t ptr);
        logic found;
        idx_t idx;
        int   j;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            j = (int'(ptr) + i) % NUM_CONSUMERS;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = idx_t'(j);
            end
        end
        return {found, idx};
    endfunction

    // Claim chain: channels pick in ascending order and each pick is removed
    // from the candidates seen by the higher-numbered channels.
    always_comb begin
        logic [NUM_CONSUMERS-1:0] avail;
        logic [CW:0]              r;
        avail = (consumer_read_valid | consumer_write_valid) & ~claimed;
        r     = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            pick_hit[ch] = 1'b0;
            pick_idx[ch] = '0;
            r = rr_pick(avail, rr_ptr[ch]);
            if (channel_state[ch] == CH_IDLE && r[CW]) begin
                pick_hit[ch]       = 1'b1;
                pick_idx[ch]       = r[CW-1:0];
                avail[r[CW-1:0]]   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            claimed              <= '0;
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            mem_read_valid       <= '0;
            mem_write_valid      <= '0;
            for (int c = 0; c < NUM_CONSUMERS; c++) begin
                consumer_read_data[c] <= '0;
            end
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                channel_state[ch]     <= CH_IDLE;
                channel_consumer[ch]  <= '0;
                rr_ptr[ch]            <= '0;
                mem_read_address[ch]  <= '0;
                mem_write_address[ch] <= '0;
                mem_write_data[ch]    <= '0;
            end
        end else begin
            // Ready outputs are pulses: cleared every cycle unless set below.
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                case (channel_state[ch])
                    CH_IDLE: begin
                        if (pick_hit[ch]) begin
                            channel_consumer[ch]   <= pick_idx[ch];
                            claimed[pick_idx[ch]]  <= 1'b1;
                            // Read has priority when both valids are high.
                            if (consumer_read_valid[pick_idx[ch]]) begin
                                mem_read_valid[ch]   <= 1'b1;
                                mem_read_address[ch] <= consumer_read_address[pick_idx[ch]];
                                channel_state[ch]    <= CH_READ_WAITING;
                            end else begin
                                mem_write_valid[ch]   <= 1'b1;
                                mem_write_address[ch] <= consumer_write_address[pick_idx[ch]];
                                mem_write_data[ch]    <= consumer_write_data[pick_idx[ch]];
                                channel_state[ch]     <= CH_WRITE_WAITING;
                            end
                        end
                    end
                    CH_READ_WAITING: begin
                        if (mem_read_ready[ch]) begin
                            mem_read_valid[ch]                        <= 1'b0;
                            consumer_read_data[channel_consumer[ch]]  <= mem_read_data[ch];
                            consumer_read_ready[channel_consumer[ch]] <= 1'b1;
                            channel_state[ch]                         <= CH_RELAYING;
                        end
                    end
                    CH_WRITE_WAITING: begin
                        if (mem_write_ready[ch]) begin
                            mem_write_valid[ch]                        <= 1'b0;
                            consumer_write_ready[channel_consumer[ch]] <= 1'b1;
                            channel_state[ch]                          <= CH_RELAYING;
                        end
                    end
                    CH_RELAYING: begin
                        if (!consumer_read_valid[channel_consumer[ch]] &&
                            !consumer_write_valid[channel_consumer[ch]]) begin
                            claimed[channel_consumer[ch]] <= 1'b0;
                            rr_ptr[ch] <= (channel_consumer[ch] == idx_t'(NUM_CONSUMERS - 1)) ?
                                          '0 : channel_consumer[ch] + idx_t'(1);
                            channel_state[ch] <= CH_IDLE;
                        end
                    end
                    default: channel_state[ch] <= CH_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_data_memory_controller.sv
module tb_data_memory_controller;
    import data_memory_controller_pkg::*;

    localparam int NC  = 8;
    localparam int NCH = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT A: 8 consumers, 2 channels ----------------
    logic [NC-1:0]        a_rv, a_rr, a_wv, a_wr;
    data_memory_address_t a_ra [NC];
    data_memory_address_t a_wa [NC];
    data_t                a_rd [NC];
    data_t                a_wd [NC];
    logic [NCH-1:0]       a_mrv, a_mrr, a_mwv, a_mwr;
    data_memory_address_t a_mra [NCH];
    data_memory_address_t a_mwa [NCH];
    data_t                a_mrd [NCH];
    data_t                a_mwd [NCH];
    mem_channel_state_t   a_st  [NCH];

    data_memory_controller #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH)) dut_a (
        .clk(clk), .reset(reset),
        .consumer_read_valid(a_rv), .consumer_read_address(a_ra),
        .consumer_read_ready(a_rr), .consumer_read_data(a_rd),
        .consumer_write_valid(a_wv), .consumer_write_address(a_wa),
        .consumer_write_data(a_wd), .consumer_write_ready(a_wr),
        .mem_read_valid(a_mrv), .mem_read_address(a_mra),
        .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
        .mem_write_valid(a_mwv), .mem_write_address(a_mwa),
        .mem_write_data(a_mwd), .mem_write_ready(a_mwr),
        .channel_state(a_st)
    );

    // ---------------- DUT B: 8 consumers, 1 channel ----------------
    logic [NC-1:0]        b_rv, b_rr, b_wv, b_wr;
    data_memory_address_t b_ra [NC];
    data_memory_address_t b_wa [NC];
    data_t                b_rd [NC];
    data_t                b_wd [NC];
    logic [0:0]           b_mrv, b_mrr, b_mwv, b_mwr;
    data_memory_address_t b_mra [1];
    data_memory_address_t b_mwa [1];
    data_t                b_mrd [1];
    data_t                b_mwd [1];
    mem_channel_state_t   b_st  [1];

    data_memory_controller #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(1)) dut_b (
        .clk(clk), .reset(reset),
        .consumer_read_valid(b_rv), .consumer_read_address(b_ra),
        .consumer_read_ready(b_rr), .consumer_read_data(b_rd),
        .consumer_write_valid(b_wv), .consumer_write_address(b_wa),
        .consumer_write_data(b_wd), .consumer_write_ready(b_wr),
        .mem_read_valid(b_mrv), .mem_read_address(b_mra),
        .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
        .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
        .mem_write_data(b_mwd), .mem_write_ready(b_mwr),
        .channel_state(b_st)
    );

    // ---------------- scoreboard counters ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    data_t mem_model [256];
    int    mem_lat;
    int    a_cnt [NCH];

    initial begin
        a_mrr = '0; a_mwr = '0; b_mrr = '0; b_mwr = '0;
        b_mrd[0] = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            a_mrd[ch] = '0;
            a_cnt[ch] = 0;
        end
        forever begin
            @(posedge clk); #1;
            for (int ch = 0; ch < NCH; ch++) begin
                a_mrr[ch] = 1'b0;
                a_mwr[ch] = 1'b0;
                if (reset) begin
                    a_cnt[ch] = 0;
                end else if (a_mrv[ch]) begin
                    a_cnt[ch]++;
                    if (a_cnt[ch] >= mem_lat) begin
                        a_mrr[ch] = 1'b1;
                        a_mrd[ch] = mem_model[a_mra[ch]];
                        a_cnt[ch] = 0;
                    end
                end else if (a_mwv[ch]) begin
                    a_cnt[ch]++;
                    if (a_cnt[ch] >= mem_lat) begin
                        a_mwr[ch] = 1'b1;
                        mem_model[a_mwa[ch]] = a_mwd[ch];
                        a_cnt[ch] = 0;
                    end
                end else begin
                    a_cnt[ch] = 0;
                end
            end
            // DUT B memory answers reads one cycle after seeing the request.
            b_mrr[0] = 1'b0;
            if (!reset && b_mrv[0]) begin
                b_mrr[0] = 1'b1;
                b_mrd[0] = 16'h5000 | {8'h00, b_mra[0]};
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Single transaction on DUT A with only consumer c active. Starts and ends
    // one time unit after a rising edge.
    task automatic run_txn(input logic is_write, input int c, input logic [7:0] addr,
                           input logic [15:0] wdata, input logic [15:0] exp_rdata,
                           input string tag);
        int   n;
        int   extra;
        logic seen;
        @(posedge clk); #1;
        if (is_write) begin
            a_wv[c] = 1'b1; a_wa[c] = addr; a_wd[c] = wdata;
        end else begin
            a_rv[c] = 1'b1; a_ra[c] = addr;
        end
        n = 0; seen = 1'b0;
        while (!seen && n < 10) begin
            @(posedge clk); #1;
            n++;
            seen = is_write ? a_mwv[0] : a_mrv[0];
        end
        check({tag, " mem req latency"}, n, 1);
        check({tag, " ch1 unused"}, {30'd0, a_mrv[1], a_mwv[1]}, 0);
        if (is_write) begin
            check({tag, " mem_write_address"}, a_mwa[0], addr);
            check({tag, " mem_write_data"}, a_mwd[0], wdata);
        end else begin
            check({tag, " mem_read_address"}, a_mra[0], addr);
        end
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            seen = is_write ? a_wr[c] : a_rr[c];
        end
        check({tag, " ready seen"}, seen, 1);
        if (!is_write) check({tag, " read data"}, a_rd[c], exp_rdata);
        // Ready must be gone one cycle later; valid is still high at that edge.
        @(posedge clk); #1;
        check({tag, " ready width"}, is_write ? a_wr[c] : a_rr[c], 0);
        extra = (a_mrv != 0 || a_mwv != 0) ? 1 : 0;
        a_rv[c] = 1'b0;
        a_wv[c] = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (a_mrv != 0 || a_mwv != 0) extra++;
        end
        check({tag, " no re-request"}, extra, 0);
        check({tag, " ch0 idle"}, a_st[0], CH_IDLE);
        if (!is_write) check({tag, " read data held"}, a_rd[c], exp_rdata);
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        is_write;
        int          consumer;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    // ---------------- main sequence ----------------
    initial begin
        int          n;
        int          cnt;
        logic        seen;
        int          served [NC];
        logic        drop_next [NC];
        int          phase [NC];
        logic [31:0] exp_q [$];

        reset = 1'b1;
        a_rv = '0; a_wv = '0; b_rv = '0; b_wv = '0;
        for (int i = 0; i < NC; i++) begin
            a_ra[i] = '0; a_wa[i] = '0; a_wd[i] = '0;
            b_ra[i] = '0; b_wa[i] = '0; b_wd[i] = '0;
        end
        for (int i = 0; i < 256; i++) mem_model[i] = '0;
        for (int i = 0; i < NC; i++) mem_model[i] = 16'hA000 + 16'(i);
        mem_model[8'h10] = 16'h00AB;
        mem_model[8'h33] = 16'h1234;
        mem_lat = 2;

        vecs[0] = '{1'b0, 3, 8'h10, 16'h0000, 16'h00AB};
        vecs[1] = '{1'b1, 0, 8'h20, 16'h0055, 16'h0000};
        vecs[2] = '{1'b0, 7, 8'h20, 16'h0000, 16'h0055};
        vecs[3] = '{1'b1, 5, 8'h33, 16'hBEEF, 16'h0000};
        vecs[4] = '{1'b0, 1, 8'h33, 16'h0000, 16'hBEEF};
        vecs[5] = '{1'b0, 6, 8'hFF, 16'h0000, 16'h0000};
        vecs[6] = '{1'b1, 4, 8'hFF, 16'hFFFF, 16'h0000};
        vecs[7] = '{1'b0, 4, 8'hFF, 16'h0000, 16'hFFFF};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset mem_read_valid", a_mrv, 0);
        check("reset mem_write_valid", a_mwv, 0);
        check("reset consumer_read_ready", a_rr, 0);
        check("reset consumer_write_ready", a_wr, 0);
        check("reset ch0 state", a_st[0], CH_IDLE);
        check("reset read data c3", a_rd[3], 0);
        @(negedge clk); reset = 1'b0;

        // Single transactions from the table
        for (int v = 0; v < 8; v++) begin
            run_txn(vecs[v].is_write, vecs[v].consumer, vecs[v].addr,
                    vecs[v].wdata, vecs[v].exp_rdata, $sformatf("vec%0d", v));
        end
        check("c3 data kept across others", a_rd[3], 16'h00AB);

        // Reset while channel 0 waits on memory
        mem_lat = 6;
        a_rv[2] = 1'b1; a_ra[2] = 8'h10;
        n = 0;
        while (!a_mrv[0] && n < 10) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        check("midrst ch0 waiting", a_st[0], CH_READ_WAITING);
        @(negedge clk); reset = 1'b1; #1;
        check("midrst mem_read_valid", a_mrv, 0);
        check("midrst mem_read_address", a_mra[0], 0);
        check("midrst ch0 state", a_st[0], CH_IDLE);
        check("midrst read data c3", a_rd[3], 0);
        a_rv[2] = 1'b0;
        @(negedge clk); reset = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (a_rr != 0 || a_wr != 0 || a_mrv != 0 || a_mwv != 0) cnt++;
        end
        check("midrst no activity after", cnt, 0);
        mem_lat = 2;
        run_txn(1'b0, 2, 8'h10, 16'h0000, 16'h00AB, "post-reset read");

        // Contention: all consumers read addr=index at once
        pulse_reset();
        mem_lat = 1;
        for (int c = 0; c < NC; c++) begin
            served[c] = 0; drop_next[c] = 1'b0;
            a_ra[c] = 8'(c);
        end
        a_rv = '1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) begin
                check("contention first issue", a_mrv, 2'b11);
                check("contention ch0 addr", a_mra[0], 0);
                check("contention ch1 addr", a_mra[1], 1);
            end
            if (a_mrv == 2'b11) check("contention distinct consumers", a_mra[0] != a_mra[1], 1);
            for (int c = 0; c < NC; c++) begin
                if (a_rr[c]) begin
                    served[c]++;
                    check($sformatf("contention data c%0d", c), a_rd[c], 16'hA000 + 16'(c));
                    drop_next[c] = 1'b1;
                end else if (drop_next[c]) begin
                    a_rv[c] = 1'b0;
                    drop_next[c] = 1'b0;
                end
            end
        end
        for (int c = 0; c < NC; c++) check($sformatf("contention served once c%0d", c), served[c], 1);

        // Simultaneous read + write from consumer 2: read first
        a_rv[2] = 1'b1; a_ra[2] = 8'h10;
        a_wv[2] = 1'b1; a_wa[2] = 8'h40; a_wd[2] = 16'h7777;
        @(posedge clk); #1;
        check("rw read issued", a_mrv[0], 1);
        check("rw write held off", a_mwv, 0);
        check("rw read addr", a_mra[0], 8'h10);
        n = 0;
        while (!a_rr[2] && n < 10) begin @(posedge clk); #1; n++; end
        check("rw read ready", a_rr[2], 1);
        check("rw read data", a_rd[2], 16'h00AB);
        check("rw no write ready yet", a_wr[2], 0);
        @(posedge clk); #1;
        a_rv[2] = 1'b0; a_wv[2] = 1'b0;
        @(posedge clk); #1;
        a_wv[2] = 1'b1;
        n = 0;
        while (!a_mwv[0] && n < 10) begin @(posedge clk); #1; n++; end
        check("rw write issued", a_mwv[0], 1);
        check("rw write addr", a_mwa[0], 8'h40);
        check("rw write data", a_mwd[0], 16'h7777);
        n = 0;
        while (!a_wr[2] && n < 10) begin @(posedge clk); #1; n++; end
        check("rw write ready", a_wr[2], 1);
        @(posedge clk); #1;
        a_wv[2] = 1'b0;
        check("rw memory written", mem_model[8'h40], 16'h7777);

        // Round-robin fairness on the single-channel instance
        exp_q.push_back(0); exp_q.push_back(5);
        exp_q.push_back(0); exp_q.push_back(5);
        for (int c = 0; c < NC; c++) phase[c] = 0;
        b_ra[0] = 8'h01; b_ra[5] = 8'h05;
        b_rv[0] = 1'b1;  b_rv[5] = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
            for (int c = 0; c < NC; c += 5) begin
                if (b_rr[c]) begin
                    check("fairness order", c, exp_q.pop_front());
                    check("fairness data", b_rd[c], 16'h5000 | {8'h00, b_ra[c]});
                    phase[c] = 1;
                end else if (phase[c] == 1) begin
                    b_rv[c] = 1'b0; phase[c] = 2;
                end else if (phase[c] == 2) begin
                    b_rv[c] = 1'b1; phase[c] = 0;
                end
            end
        end
        check("fairness all services seen", exp_q.size(), 0);
        b_rv = '0;
        repeat (4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
